// File: rtl/mdu_ctrl_pkg.sv
// Shared constants for the multiply/divide sequencing controller:
// op encodings, default latencies and the FSM state type.
package mdu_ctrl_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // Ops that occupy the unit for a busy period.
    function automatic logic is_md_op(input logic [2:0] op);
        return (op <= OP_DIVU);
    endfunction

    // Divides take the longer latency.
    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_md_arith.sv
// Combinational multiply/divide datapath. Produces the full HI/LO result
// for mult/multu/div/divu and flags a zero divisor so the caller can
// suppress the commit.
module md_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] pend_hi,
    output logic [31:0] pend_lo,
    output logic        div_zero
);

    logic [63:0] prod_s;

    // Result selection per op; the signed overflow case is pinned explicitly
    // so it never depends on the divider's handling of an unrepresentable quotient.
    always_comb begin
        prod_s   = 64'd0;
        pend_hi  = 32'd0;
        pend_lo  = 32'd0;
        div_zero = 1'b0;
        case (op)
            OP_MULT: begin
                prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                pend_hi = prod_s[63:32];
                pend_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                prod_s  = {32'd0, a} * {32'd0, b};
                pend_hi = prod_s[63:32];
                pend_lo = prod_s[31:0];
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    div_zero = 1'b1;
                end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
                    pend_lo = 32'h8000_0000;
                    pend_hi = 32'd0;
                end else begin
                    pend_lo = $signed(a) / $signed(b);
                    pend_hi = $signed(a) % $signed(b);
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    div_zero = 1'b1;
                end else begin
                    pend_lo = a / b;
                    pend_hi = a % b;
                end
            end
            default: begin
                div_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller. Latches the result on start, counts
// down a fixed busy period, then commits to the architectural HI/LO.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             wr_hilo,
    input  logic [2:0]       op,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic             md_req,
    output logic [31:0]      hi,
    output logic [31:0]      lo,
    output logic             busy,
    output logic [CNT_W-1:0] tnew,
    output logic             stall_md
);

    md_state_e        state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             busy_r;
    logic [31:0]      hi_r, lo_r, pend_hi_r, pend_lo_r;
    logic             pend_dz_r;
    logic             load_s, commit_s, wr_hi_s, wr_lo_s;
    logic [31:0]      arith_hi_s, arith_lo_s;
    logic             arith_dz_s;

    md_arith u_md_arith (
        .op       (op),
        .a        (a),
        .b        (b),
        .pend_hi  (arith_hi_s),
        .pend_lo  (arith_lo_s),
        .div_zero (arith_dz_s)
    );

    // Next-state, countdown and HI/LO write decisions. Issue requests while
    // busy are dropped; start takes priority over wr_hilo.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        load_s      = 1'b0;
        commit_s    = 1'b0;
        wr_hi_s     = 1'b0;
        wr_lo_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (is_md_op(op)) begin
                        state_nxt_s = ST_BUSY;
                        cnt_nxt_s   = is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        load_s      = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (wr_hilo) begin
                    wr_hi_s = (op == OP_MTHI);
                    wr_lo_s = (op == OP_MTLO);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_nxt_s = cnt_r - CNT_W'(1);
                if (cnt_r <= CNT_W'(1)) begin
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    commit_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state, countdown and the registered busy flag (mirrors cnt != 0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (cnt_nxt_s != {CNT_W{1'b0}});
        end
    end

    // Pending result captured from the operands sampled on the start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_dz_r <= 1'b0;
        end else if (load_s) begin
            pend_hi_r <= arith_hi_s;
            pend_lo_r <= arith_lo_s;
            pend_dz_r <= arith_dz_s;
        end
    end

    // Architectural HI/LO: written on commit (unless divide by zero) or mthi/mtlo.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (commit_s) begin
            if (!pend_dz_r) begin
                hi_r <= pend_hi_r;
                lo_r <= pend_lo_r;
            end
        end else begin
            if (wr_hi_s) hi_r <= a;
            if (wr_lo_s) lo_r <= a;
        end
    end

    assign hi       = hi_r;
    assign lo       = lo_r;
    assign busy     = busy_r;
    assign tnew     = cnt_r;
    assign stall_md = md_req & (start | busy_r);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus randomized issue
// traffic, compared each cycle against a cycle-count based reference model.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, wr_hilo, md_req;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        busy, stall_md;
    logic [3:0]  tnew;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: absolute cycle count and the cycle at which the
    // in-flight operation completes.
    int          cyc = 0;
    int          m_done = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi, m_plo;
    logic        m_dz;
    int          stall_seen;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .wr_hilo(wr_hilo), .op(op),
        .a(a), .b(b), .md_req(md_req), .hi(hi), .lo(lo), .busy(busy),
        .tnew(tnew), .stall_md(stall_md)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue requests must never reach the unit while it is busy.
    always @(posedge clk) begin
        if (!reset && busy) check("issue_while_busy", {63'd0, start | wr_hilo}, 64'd0);
    end

    // Architectural result of an MD op, computed with wide integer arithmetic.
    function automatic void ref_md(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                                   output logic [31:0] rh, output logic [31:0] rl, output logic dz);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(aa);
        sb = $signed(bb);
        rh = 32'd0; rl = 32'd0; dz = 1'b0;
        case (o)
            3'd0: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
            3'd1: begin p = {32'd0, aa} * {32'd0, bb}; rh = p[63:32]; rl = p[31:0]; end
            3'd2: begin
                if (bb == 32'd0) dz = 1'b1;
                else begin
                    q = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
                    if ((sa < 0) != (sb < 0)) q = -q;
                    r = sa - q * sb;
                    p = q; rl = p[31:0];
                    p = r; rh = p[31:0];
                end
            end
            3'd3: begin
                if (bb == 32'd0) dz = 1'b1;
                else begin rl = aa / bb; rh = aa % bb; end
            end
            default: dz = 1'b0;
        endcase
    endfunction

    function automatic logic m_busy();
        return m_done > cyc;
    endfunction

    task automatic model_edge(input logic st, input logic wh, input logic [2:0] o,
                              input logic [31:0] aa, input logic [31:0] bb);
        logic was_busy;
        was_busy = m_busy();
        cyc++;
        if (was_busy) begin
            if (cyc == m_done && !m_dz) begin m_hi = m_phi; m_lo = m_plo; end
        end else if (st) begin
            if (o <= 3'd3) begin
                ref_md(o, aa, bb, m_phi, m_plo, m_dz);
                m_done = cyc + ((o >= 3'd2) ? 10 : 5);
            end
        end else if (wh) begin
            if (o == 3'd4) m_hi = aa;
            else if (o == 3'd5) m_lo = aa;
        end
    endtask

    task automatic check_outputs();
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        check("busy", busy, m_busy());
        check("tnew", tnew, m_busy() ? 64'(m_done - cyc) : 64'd0);
    endtask

    // One cycle: drive inputs just after an edge, check the combinational
    // stall, take the edge, then check registered outputs.
    task automatic step(input logic st, input logic wh, input logic [2:0] o,
                        input logic [31:0] aa, input logic [31:0] bb, input logic mr);
        start = st; wr_hilo = wh; op = o; a = aa; b = bb; md_req = mr;
        #1;
        check("stall_md", stall_md, mr & (st | m_busy()));
        if (stall_md) stall_seen++;
        @(posedge clk);
        model_edge(st, wh, o, aa, bb);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input logic mr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, $urandom, $urandom, mr);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  ro;
        int          k;
        reset = 1'b1; start = 1'b0; wr_hilo = 1'b0; md_req = 1'b0;
        op = 3'd0; a = 32'd0; b = 32'd0;
        #12;
        check("rst_hi", hi, 64'd0);
        check("rst_lo", lo, 64'd0);
        check("rst_busy", busy, 64'd0);
        check("rst_tnew", tnew, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // mult -1 * 2
        step(1'b1, 1'b0, 3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("mult_tnew0", tnew, 64'd5);
        idle(5, 1'b0);
        check("mult_hi", hi, 64'hFFFF_FFFF);
        check("mult_lo", lo, 64'hFFFF_FFFE);

        // multu 0xFFFFFFFF * 2
        step(1'b1, 1'b0, 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        idle(5, 1'b0);
        check("multu_hi", hi, 64'h1);
        check("multu_lo", lo, 64'hFFFF_FFFE);

        // div / divu -7, 2
        step(1'b1, 1'b0, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(10, 1'b0);
        check("div_hi", hi, 64'hFFFF_FFFF);
        check("div_lo", lo, 64'hFFFF_FFFD);
        step(1'b1, 1'b0, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(10, 1'b0);
        check("divu_hi", hi, 64'h1);
        check("divu_lo", lo, 64'h7FFF_FFFC);

        // divide by zero after mthi/mtlo preload
        step(1'b0, 1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b0);
        step(1'b0, 1'b1, 3'd5, 32'h9ABC_DEF0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 3'd2, 32'd55, 32'd0, 1'b0);
        idle(9, 1'b0);
        check("dz_busy_last", busy, 64'd1);
        idle(1, 1'b0);
        check("dz_hi", hi, 64'h1234_5678);
        check("dz_lo", lo, 64'h9ABC_DEF0);

        // signed overflow
        step(1'b1, 1'b0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(10, 1'b0);
        check("ovf_lo", lo, 64'h8000_0000);
        check("ovf_hi", hi, 64'd0);

        // stall window on mult with md_req held
        stall_seen = 0;
        step(1'b1, 1'b0, 3'd0, 32'd3, 32'd7, 1'b1);
        idle(6, 1'b1);
        check("stall_cycles", 64'(stall_seen), 64'd6);

        // async reset mid-divide at tnew = 3
        step(1'b1, 1'b0, 3'd3, 32'd1000, 32'd7, 1'b0);
        idle(7, 1'b0);
        check("pre_rst_tnew", tnew, 64'd3);
        #2;
        reset = 1'b1;
        #1;
        m_hi = 32'd0; m_lo = 32'd0; m_done = cyc;
        check("arst_busy", busy, 64'd0);
        check("arst_tnew", tnew, 64'd0);
        check("arst_hi", hi, 64'd0);
        check("arst_lo", lo, 64'd0);
        @(posedge clk);
        cyc++;
        #1;
        reset = 1'b0;
        idle(12, 1'b0);
        check("no_commit_lo", lo, 64'd0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            ra = $urandom; rb = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 9);
            if (m_busy()) begin
                step(1'b0, 1'b0, 3'($urandom_range(0, 7)), ra, rb, 1'($urandom));
            end else begin
                k = $urandom_range(0, 9);
                ro = 3'($urandom_range(0, 3));
                if (k <= 4)      step(1'b1, 1'b0, ro, ra, rb, 1'($urandom));
                else if (k <= 6) step(1'b0, 1'b1, 3'($urandom_range(4, 5)), ra, rb, 1'($urandom));
                else if (k == 7) step(1'b1, 1'($urandom), 3'($urandom_range(4, 7)), ra, rb, 1'($urandom));
                else if (k == 8) step(1'b0, 1'b0, ro, ra, rb, 1'($urandom));
                else             step(1'b1, 1'b1, ro, ra, rb, 1'($urandom));
            end
        end
        idle(12, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
